hpdcache_victim_ctrl: RTL

Sequencer and arbiter in front of the HPDcache replacement-policy engine (the PLRU victim selector or equivalent). It collects replacement-state update requests from several hit-path requesters into a small FIFO and drains them into the engine's single update port. It also runs victim-selection transactions for the miss handler: directory read, engine query, one-hot victim response, and a touch-update of the chosen way. It guarantees that no selection in a set observes stale replacement state for that set.

---
 rtl/hpdcache_pkg.sv | 32 +++
 rtl/hpdcache_victim_ctrl_rrarb.sv | 51 +++++
 rtl/hpdcache_victim_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_pkg.sv
// Shared types for the HPDcache replacement-policy front end: cache
// configuration, victim-selection FSM states and geometry helpers.
package hpdcache_pkg;

  typedef struct packed {
    int unsigned sets;
    int unsigned ways;
  } hpdcache_user_cfg_t;

  typedef struct packed {
    hpdcache_user_cfg_t u;
  } hpdcache_cfg_t;

  typedef enum logic [2:0] {
    VC_IDLE,
    VC_DRD,
    VC_DLAT,
    VC_SEL,
    VC_TOUCH,
    VC_RSP
  } victim_state_e;

  // A zeroed configuration still elaborates as a minimal 2-set, 1-way cache.
  function automatic int hpdcache_set_width(hpdcache_cfg_t cfg);
    return (cfg.u.sets > 2) ? $clog2(cfg.u.sets) : 1;
  endfunction

  function automatic int hpdcache_way_count(hpdcache_cfg_t cfg);
    return (cfg.u.ways > 1) ? int'(cfg.u.ways) : 1;
  endfunction

endpackage

// File: rtl/hpdcache_victim_ctrl_rrarb.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer past the winner only when the grant is consumed.
module hpdcache_rrarb #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [N-1:0] gnt
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] win_idx;
  logic             hi_found;
  logic             lo_found;

  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx   = IDX_W'(i);
        lo_found = 1'b1;
        if (IDX_W'(i) >= ptr_q) begin
          hi_idx   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
    gnt     = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = lo_found && (win_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (ack && lo_found) begin
      ptr_q <= (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/hpdcache_victim_ctrl.sv
// Sequencer in front of the replacement engine: queues hit-path updates and
// runs victim selections that never observe a pending update to their set.
module hpdcache_victim_ctrl
  import hpdcache_pkg::*;
#(
  parameter  hpdcache_cfg_t HPDcacheCfg = '0,
  parameter  int unsigned   NREQ        = 2,
  parameter  int unsigned   FIFO_DEPTH  = 4,
  localparam int unsigned   SET_W       = hpdcache_set_width(HPDcacheCfg),
  localparam int unsigned   WAYS        = hpdcache_way_count(HPDcacheCfg)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NREQ-1:0]             updt_req_valid_i,
  output logic [NREQ-1:0]             updt_req_ready_o,
  input  logic [NREQ-1:0][SET_W-1:0]  updt_req_set_i,
  input  logic [NREQ-1:0][WAYS-1:0]   updt_req_way_i,
  input  logic                        sel_req_valid_i,
  output logic                        sel_req_ready_o,
  input  logic [SET_W-1:0]            sel_req_set_i,
  output logic                        sel_rsp_valid_o,
  input  logic                        sel_rsp_ready_i,
  output logic [WAYS-1:0]             sel_rsp_way_o,
  output logic                        dir_rd_o,
  output logic [SET_W-1:0]            dir_rd_set_o,
  input  logic [WAYS-1:0]             dir_valid_i,
  input  logic [WAYS-1:0]             dir_wback_i,
  input  logic [WAYS-1:0]             dir_dirty_i,
  input  logic [WAYS-1:0]             dir_shared_i,
  input  logic [WAYS-1:0]             dir_fetch_i,
  output logic                        eng_updt_o,
  output logic [SET_W-1:0]            eng_updt_set_o,
  output logic [WAYS-1:0]             eng_updt_way_o,
  output logic                        eng_sel_o,
  output logic [SET_W-1:0]            eng_sel_set_o,
  output logic [WAYS-1:0]             eng_dir_valid_o,
  output logic [WAYS-1:0]             eng_dir_wback_o,
  output logic [WAYS-1:0]             eng_dir_dirty_o,
  output logic [WAYS-1:0]             eng_dir_shared_o,
  output logic [WAYS-1:0]             eng_dir_fetch_o,
  input  logic [WAYS-1:0]             eng_victim_way_i
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [SET_W-1:0] set;
    logic [WAYS-1:0]  way;
  } updt_entry_t;

  victim_state_e    state_q, state_d;
  logic [NREQ-1:0]  gnt;
  logic             push, pop, full, empty, touch, set_hit;
  logic [PTR_W:0]   wptr_q, rptr_q, fifo_cnt;
  logic [PTR_W-1:0] slot_off;
  updt_entry_t      fifo_mem [FIFO_DEPTH];
  updt_entry_t      push_entry, head;
  logic [SET_W-1:0] sel_set_p0;
  logic             vld_p1;
  logic [WAYS-1:0]  dir_valid_p1, dir_wback_p1, dir_dirty_p1, dir_shared_p1, dir_fetch_p1;
  logic [WAYS-1:0]  rsp_way_p2;

  hpdcache_rrarb #(.N(NREQ)) i_rrarb (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .req   (updt_req_valid_i),
    .ack   (~full),
    .gnt   (gnt)
  );

  // ---- update FIFO with set-match lookup ----
  assign full             = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                            (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign empty            = (wptr_q == rptr_q);
  assign fifo_cnt         = wptr_q - rptr_q;
  assign updt_req_ready_o = gnt & {NREQ{~full}};
  assign push             = |updt_req_ready_o;
  assign pop              = ~empty & ~touch;
  assign head             = fifo_mem[rptr_q[PTR_W-1:0]];

  always_comb begin
    push_entry = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) push_entry = '{set: updt_req_set_i[i], way: updt_req_way_i[i]};
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    set_hit  = 1'b0;
    slot_off = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_off = PTR_W'(i) - rptr_q[PTR_W-1:0];
      if (({1'b0, slot_off} < fifo_cnt) && (fifo_mem[i].set == sel_set_p0)) set_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q[PTR_W-1:0]] <= push_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // ---- selection FSM ----
  always_comb begin
    state_d         = state_q;
    sel_req_ready_o = 1'b0;
    dir_rd_o        = 1'b0;
    eng_sel_o       = 1'b0;
    touch           = 1'b0;
    sel_rsp_valid_o = 1'b0;
    case (state_q)
      VC_IDLE: begin
        sel_req_ready_o = 1'b1;
        if (sel_req_valid_i) state_d = VC_DRD;
      end
      VC_DRD: begin
        dir_rd_o = 1'b1;
        state_d  = VC_DLAT;
      end
      VC_DLAT: begin
        if (!set_hit) state_d = VC_SEL;
      end
      VC_SEL: begin
        eng_sel_o = 1'b1;
        state_d   = (|eng_victim_way_i) ? VC_TOUCH : VC_RSP;
      end
      VC_TOUCH: begin
        touch   = 1'b1;
        state_d = VC_RSP;
      end
      VC_RSP: begin
        sel_rsp_valid_o = 1'b1;
        if (sel_rsp_ready_i) state_d = VC_IDLE;
      end
      default: state_d = VC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= VC_IDLE;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= dir_rd_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sel_req_valid_i && sel_req_ready_o) sel_set_p0 <= sel_req_set_i;
  end

  // ---- p1: directory state, one cycle after the read strobe ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_valid_p1  <= '0;
      dir_wback_p1  <= '0;
      dir_dirty_p1  <= '0;
      dir_shared_p1 <= '0;
      dir_fetch_p1  <= '0;
    end else if (vld_p1) begin
      dir_valid_p1  <= dir_valid_i;
      dir_wback_p1  <= dir_wback_i;
      dir_dirty_p1  <= dir_dirty_i;
      dir_shared_p1 <= dir_shared_i;
      dir_fetch_p1  <= dir_fetch_i;
    end
  end

  // ---- p2: engine result held as the response ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_way_p2 <= '0;
    end else if (eng_sel_o) begin
      rsp_way_p2 <= eng_victim_way_i;
    end
  end

  assign dir_rd_set_o     = dir_rd_o ? sel_set_p0 : '0;
  assign eng_sel_set_o    = eng_sel_o ? sel_set_p0 : '0;
  assign eng_updt_o       = touch | pop;
  assign eng_updt_set_o   = touch ? sel_set_p0 : (pop ? head.set : '0);
  assign eng_updt_way_o   = touch ? rsp_way_p2 : (pop ? head.way : '0);
  assign eng_dir_valid_o  = dir_valid_p1;
  assign eng_dir_wback_o  = dir_wback_p1;
  assign eng_dir_dirty_o  = dir_dirty_p1;
  assign eng_dir_shared_o = dir_shared_p1;
  assign eng_dir_fetch_o  = dir_fetch_p1;
  assign sel_rsp_way_o    = rsp_way_p2;

endmodule
